// File: rtl/simon_tone_if.sv
// Request/status bundle between the Simon game FSM (master) and the tone sequencer (slave).
`timescale 1ns/1ps
interface simon_tone_if;
   logic        play_valid;
   logic        play_ready;
   logic [2:0]  tone_id;
   logic [11:0] dur_ms;
   logic        stop;
   logic [31:0] desiredFrequency;
   logic        busy;
   logic        done;

   modport master (
      output play_valid, tone_id, dur_ms, stop,
      input  play_ready, desiredFrequency, busy, done
   );

   modport slave (
      input  play_valid, tone_id, dur_ms, stop,
      output play_ready, desiredFrequency, busy, done
   );
endinterface

// File: rtl/simon_tone_sequencer.sv
// Plays one timed tone followed by a silent gap, then pulses done; feeds desiredFrequency to the tone generator.
// Optional macro SIMON_ERR_WARBLE_EN: error tone (id 4) alternates FREQ_ERR / 2*FREQ_ERR every 50 ms.
//
// state | meaning
// IDLE  | waiting for a request, play_ready high unless stop
// TONE  | driving the mapped frequency for dur_ms milliseconds
// GAP   | silent inter-tone gap of GAP_MS milliseconds
`timescale 1ns/1ps
module simon_tone_sequencer #(
   parameter int CLK_HZ   = 50000000,
   parameter int GAP_MS   = 50,
   parameter int FREQ_C0  = 209,
   parameter int FREQ_C1  = 252,
   parameter int FREQ_C2  = 310,
   parameter int FREQ_C3  = 415,
   parameter int FREQ_ERR = 42
) (
   input  logic         FPGA_CLK1_50,
   input  logic         reset,
   simon_tone_if.slave  bus
);
   localparam int MS_CYC = CLK_HZ / 1000;
   localparam int PW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(MS_CYC - 1);
   localparam logic [11:0]   GAP_LAST = 12'(GAP_MS - 1);

   typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

   state_t         state_q;
   logic [PW-1:0]  pre_q;
   logic [11:0]    ms_q;
   logic [11:0]    dur_q;
   logic [31:0]    freq_q;
   logic           busy_q;
   logic           done_q;
   logic           ms_tick;
   logic           accept;

`ifdef SIMON_ERR_WARBLE_EN
   logic [2:0]     id_q;
   logic [5:0]     wms_q;
   logic           whi_q;
`endif

   function automatic logic [31:0] tone_freq(input logic [2:0] id);
      case (id)
         3'd0:    return 32'(FREQ_C0);
         3'd1:    return 32'(FREQ_C1);
         3'd2:    return 32'(FREQ_C2);
         3'd3:    return 32'(FREQ_C3);
         3'd4:    return 32'(FREQ_ERR);
         default: return 32'd0;
      endcase
   endfunction

   assign ms_tick              = (pre_q == PRE_LAST);
   assign bus.play_ready       = (state_q == IDLE) && !bus.stop;
   assign accept               = bus.play_valid && bus.play_ready;
   assign bus.desiredFrequency = freq_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;

   always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pre_q   <= '0;
         ms_q    <= '0;
         dur_q   <= '0;
         freq_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SIMON_ERR_WARBLE_EN
         id_q    <= '0;
         wms_q   <= '0;
         whi_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         // prescaler parks at zero in IDLE so the first ms after accept is full length
         pre_q  <= (state_q == IDLE || ms_tick) ? '0 : pre_q + PW'(1);
         case (state_q)
            IDLE: begin
               if (accept) begin
                  dur_q <= bus.dur_ms;
                  ms_q  <= '0;
`ifdef SIMON_ERR_WARBLE_EN
                  id_q  <= bus.tone_id;
                  wms_q <= '0;
                  whi_q <= 1'b0;
`endif
                  if (bus.dur_ms == 12'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= TONE;
                     freq_q  <= tone_freq(bus.tone_id);
                     busy_q  <= 1'b1;
                  end
               end
            end
            TONE: begin
               if (bus.stop) begin
                  state_q <= IDLE;
                  freq_q  <= '0;
                  busy_q  <= 1'b0;
                  ms_q    <= '0;
               end else if (ms_tick) begin
                  if (ms_q == dur_q - 12'd1) begin
                     ms_q   <= '0;
                     freq_q <= '0;
                     if (GAP_MS == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= GAP;
                     end
                  end else begin
                     ms_q <= ms_q + 12'd1;
`ifdef SIMON_ERR_WARBLE_EN
                     if (id_q == 3'd4) begin
                        if (wms_q == 6'd49) begin
                           wms_q  <= '0;
                           whi_q  <= !whi_q;
                           freq_q <= whi_q ? 32'(FREQ_ERR) : 32'(2 * FREQ_ERR);
                        end else begin
                           wms_q <= wms_q + 6'd1;
                        end
                     end
`endif
                  end
               end
            end
            GAP: begin
               if (bus.stop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ms_q    <= '0;
               end else if (ms_tick) begin
                  if (ms_q == GAP_LAST) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     ms_q    <= '0;
                  end else begin
                     ms_q <= ms_q + 12'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               freq_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Bench for simon_tone_sequencer: timeline model of each accepted request plus literal pinned points.
`timescale 1ns/1ps
module tb_simon_tone_sequencer;
   localparam int CLK_HZ = 10000;
   localparam int GAP_MS = 2;
   localparam int MS     = CLK_HZ / 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   simon_tone_if bus_if();

   simon_tone_sequencer #(.CLK_HZ(CLK_HZ), .GAP_MS(GAP_MS)) dut (
      .FPGA_CLK1_50(clk),
      .reset(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model: one request described by its accept edge and derived boundaries
   bit m_live = 1'b0;
   int m_T, m_D, m_id, m_idle_e, m_done_e, m_cut;

   int pin_e [64];
   int pin_f [64];
   int pin_b [64];
   int pin_d [64];
   int n_pins = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_live <= 1'b0;
      end else if ((!m_live || cyc >= m_idle_e) && bus_if.play_valid && !bus_if.stop) begin
         m_live   <= 1'b1;
         m_T      <= cyc + 1;
         m_D      <= int'(bus_if.dur_ms);
         m_id     <= int'(bus_if.tone_id);
         m_idle_e <= cyc + 1 + ((bus_if.dur_ms != 0) ? (int'(bus_if.dur_ms) + GAP_MS) * MS : 0);
         m_done_e <= cyc + 1 + ((bus_if.dur_ms != 0) ? (int'(bus_if.dur_ms) + GAP_MS) * MS : 0);
         m_cut    <= 1 << 30;
      end else if (m_live && cyc < m_idle_e && bus_if.stop) begin
         m_idle_e <= cyc + 1;
         m_cut    <= cyc + 1;
      end
      cyc <= cyc + 1;
   end

   function automatic int f_of(int id, int k);
      case (id)
         0: return 209;
         1: return 252;
         2: return 310;
         3: return 415;
         4: begin
`ifdef SIMON_ERR_WARBLE_EN
            return (((k / (50 * MS)) % 2) != 0) ? 84 : 42;
`else
            return (k >= 0) ? 42 : 42;
`endif
         end
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   // compare process: every half-period after the falling edge, and right after reset asserts
   initial begin
      forever begin
         @(negedge clk or posedge rst);
         #1;
         if (rst) begin
            chk("rst_freq",  bus_if.desiredFrequency, 0);
            chk("rst_busy",  bus_if.busy, 0);
            chk("rst_done",  bus_if.done, 0);
            chk("rst_ready", bus_if.play_ready, !bus_if.stop);
         end else begin
            automatic int  e      = cyc;
            automatic bit  active = m_live && e >= m_T && e < m_idle_e && e < m_cut;
            automatic bit  tone   = active && e < m_T + m_D * MS;
            automatic int  ef     = tone ? f_of(m_id, e - m_T) : 0;
            automatic bit  ed     = m_live && e == m_done_e && e < m_cut;
            automatic bit  idle   = !m_live || e >= m_idle_e;
            chk("freq",  bus_if.desiredFrequency, ef);
            chk("busy",  bus_if.busy, active);
            chk("done",  bus_if.done, ed);
            chk("ready", bus_if.play_ready, idle && !bus_if.stop);
            for (int i = 0; i < n_pins; i++) begin
               if (pin_e[i] == e) begin
                  chk("pin_freq", bus_if.desiredFrequency, pin_f[i]);
                  chk("pin_busy", bus_if.busy, pin_b[i]);
                  chk("pin_done", bus_if.done, pin_d[i]);
               end
            end
         end
      end
   end

   task automatic add_pin(input int e, input int f, input int b, input int d);
      pin_e[n_pins] = e;
      pin_f[n_pins] = f;
      pin_b[n_pins] = b;
      pin_d[n_pins] = d;
      n_pins++;
   endtask

   task automatic wait_to(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input int id, input int dur, output int t);
      bus_if.play_valid = 1'b1;
      bus_if.tone_id    = 3'(id);
      bus_if.dur_ms     = 12'(dur);
      @(posedge clk);
      #1;
      t = cyc;
      bus_if.play_valid = 1'b0;
   endtask

   int t1, t2, t3, t4, t5, t6, t7;

   initial begin
      bus_if.play_valid = 1'b0;
      bus_if.tone_id    = '0;
      bus_if.dur_ms     = '0;
      bus_if.stop       = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_to(cyc + 2);

      // red tone, 3 ms, then 2 ms gap
      go(2, 3, t1);
      add_pin(t1, 310, 1, 0);
      add_pin(t1 + 29, 310, 1, 0);
      add_pin(t1 + 30, 0, 1, 0);
      add_pin(t1 + 49, 0, 1, 0);
      add_pin(t1 + 50, 0, 0, 1);
      wait_to(t1 + 50);

      // back-to-back request presented in the done cycle
      go(0, 1, t2);
      add_pin(t2, 209, 1, 0);
      add_pin(t2 + 9, 209, 1, 0);
      add_pin(t2 + 10, 0, 1, 0);
      add_pin(t2 + 30, 0, 0, 1);
      wait_to(t2 + 33);

      // zero-length request
      go(1, 0, t3);
      add_pin(t3, 0, 0, 1);
      add_pin(t3 + 1, 0, 0, 0);
      wait_to(t3 + 3);

      // stop mid-tone, then stop with valid in IDLE
      go(3, 5, t4);
      add_pin(t4 + 14, 415, 1, 0);
      add_pin(t4 + 15, 0, 0, 0);
      add_pin(t4 + 16, 0, 0, 0);
      add_pin(t4 + 17, 0, 0, 0);
      wait_to(t4 + 14);
      bus_if.stop = 1'b1;
      @(posedge clk);
      #1;
      bus_if.play_valid = 1'b1;
      bus_if.tone_id    = 3'd0;
      bus_if.dur_ms     = 12'd1;
      @(posedge clk);
      #1;
      bus_if.play_valid = 1'b0;
      bus_if.stop       = 1'b0;
      wait_to(t4 + 60);

      // asynchronous reset in the gap, then a fresh request
      go(2, 1, t5);
      wait_to(t5 + 15);
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_to(cyc + 2);
      go(0, 2, t6);
      add_pin(t6, 209, 1, 0);
      add_pin(t6 + 19, 209, 1, 0);
      add_pin(t6 + 40, 0, 0, 1);
      wait_to(t6 + 42);

      // error tone, 120 ms
      go(4, 120, t7);
      add_pin(t7, 42, 1, 0);
      add_pin(t7 + 499, 42, 1, 0);
`ifdef SIMON_ERR_WARBLE_EN
      add_pin(t7 + 500, 84, 1, 0);
      add_pin(t7 + 999, 84, 1, 0);
`else
      add_pin(t7 + 500, 42, 1, 0);
      add_pin(t7 + 999, 42, 1, 0);
`endif
      add_pin(t7 + 1000, 42, 1, 0);
      add_pin(t7 + 1199, 42, 1, 0);
      add_pin(t7 + 1200, 0, 1, 0);
      add_pin(t7 + 1220, 0, 0, 1);
      wait_to(t7 + 1222);

      // random traffic: requests, ignored requests while busy, occasional stop
      for (int i = 0; i < 4000; i++) begin
         bus_if.play_valid = ($urandom_range(2, 0) == 0);
         bus_if.tone_id    = 3'($urandom_range(7, 0));
         bus_if.dur_ms     = 12'($urandom_range(4, 0));
         bus_if.stop       = ($urandom_range(49, 0) == 0);
         @(posedge clk);
         #1;
      end
      bus_if.play_valid = 1'b0;
      bus_if.stop       = 1'b0;
      wait_to(cyc + 80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
